// File: rtl/vip_pkg.sv
// Shared definitions for the vip_* video blocks: pattern and FSM encodings
// plus constant helpers for frame geometry.
package vip_pkg;

   typedef enum logic [1:0] {
      PAT_HRAMP = 2'd0,
      PAT_VRAMP = 2'd1,
      PAT_BARS  = 2'd2,
      PAT_CHECK = 2'd3
   } pattern_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   function automatic int unsigned h_total(input int unsigned disp, input int unsigned front,
                                           input int unsigned sync, input int unsigned back);
      return disp + front + sync + back;
   endfunction

   function automatic int unsigned v_total(input int unsigned disp, input int unsigned front,
                                           input int unsigned sync, input int unsigned back);
      return disp + front + sync + back;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned total);
      return (total > 1) ? $clog2(total) : 1;
   endfunction

   // First pixel of colour bar k: smallest x with (x*8)/disp >= k.
   function automatic int unsigned bar_edge(input int unsigned k, input int unsigned disp);
      return (k * disp + 7) / 8;
   endfunction

endpackage

// File: rtl/vip_dvp_timing.sv
// Raster counters and registered href/hsync/vsync decode for DVP-style sync
// generators. Counters hold at zero until one cycle after run rises.
module vip_dvp_timing
   import vip_pkg::*;
#(
   parameter int unsigned H_DISP  = 1280,
   parameter int unsigned H_FRONT = 110,
   parameter int unsigned H_SYNC  = 40,
   parameter int unsigned H_BACK  = 50,
   parameter int unsigned V_DISP  = 720,
   parameter int unsigned V_FRONT = 5,
   parameter int unsigned V_SYNC  = 5,
   parameter int unsigned V_BACK  = 20,
   localparam int unsigned H_TOTAL = h_total(H_DISP, H_FRONT, H_SYNC, H_BACK),
   localparam int unsigned V_TOTAL = v_total(V_DISP, V_FRONT, V_SYNC, V_BACK),
   localparam int unsigned HW = cnt_width(H_TOTAL),
   localparam int unsigned VW = cnt_width(V_TOTAL)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          run,
   output logic [HW-1:0] hcnt,
   output logic [VW-1:0] vcnt,
   output logic          frame_end,
   output logic          pix_vld,
   output logic          href,
   output logic          hsync,
   output logic          vsync
);

   localparam int unsigned HS_START = H_DISP + H_FRONT;
   localparam int unsigned HS_END   = HS_START + H_SYNC;
   localparam int unsigned VS_START = V_DISP + V_FRONT;
   localparam int unsigned VS_END   = VS_START + V_SYNC;

   logic          live_q;
   logic [HW-1:0] hcnt_q, hcnt_d;
   logic [VW-1:0] vcnt_q, vcnt_d;
   logic          href_q, href_d;
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic          active, h_last, v_last;

   always_comb begin
      active    = live_q & run;
      h_last    = (32'(hcnt_q) == H_TOTAL - 1);
      v_last    = (32'(vcnt_q) == V_TOTAL - 1);
      frame_end = active & h_last & v_last;
      hcnt_d    = '0;
      vcnt_d    = '0;
      if (active && !frame_end) begin
         if (h_last) begin
            vcnt_d = vcnt_q + 1'b1;
         end else begin
            hcnt_d = hcnt_q + 1'b1;
            vcnt_d = vcnt_q;
         end
      end
      href_d  = active && (32'(hcnt_q) < H_DISP) && (32'(vcnt_q) < V_DISP);
      hsync_d = active && (32'(hcnt_q) >= HS_START) && (32'(hcnt_q) < HS_END);
      vsync_d = active && (32'(vcnt_q) >= VS_START) && (32'(vcnt_q) < VS_END);
      pix_vld = href_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         live_q  <= 1'b0;
         hcnt_q  <= '0;
         vcnt_q  <= '0;
         href_q  <= 1'b0;
         hsync_q <= 1'b0;
         vsync_q <= 1'b0;
      end else begin
         live_q  <= run;
         hcnt_q  <= hcnt_d;
         vcnt_q  <= vcnt_d;
         href_q  <= href_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
      end
   end

   assign hcnt  = hcnt_q;
   assign vcnt  = vcnt_q;
   assign href  = href_q;
   assign hsync = hsync_q;
   assign vsync = vsync_q;

endmodule

// File: rtl/vip_dvp_gen.sv
// DVP frame transmitter: programmable raster timing filled with one of four
// built-in test patterns; frames always run to completion once started.
module vip_dvp_gen
   import vip_pkg::*;
#(
   parameter int unsigned BITS    = 8,
   parameter int unsigned H_DISP  = 1280,
   parameter int unsigned H_FRONT = 110,
   parameter int unsigned H_SYNC  = 40,
   parameter int unsigned H_BACK  = 50,
   parameter int unsigned V_DISP  = 720,
   parameter int unsigned V_FRONT = 5,
   parameter int unsigned V_SYNC  = 5,
   parameter int unsigned V_BACK  = 20
) (
   input  logic            pclk,
   input  logic            rst_n,
   input  logic            enable,
   input  logic [1:0]      pattern,
   output logic            out_href,
   output logic            out_hsync,
   output logic            out_vsync,
   output logic [BITS-1:0] out_data,
   output logic            frame_done,
   output logic            busy
);

   localparam int unsigned HW = cnt_width(h_total(H_DISP, H_FRONT, H_SYNC, H_BACK));
   localparam int unsigned VW = cnt_width(v_total(V_DISP, V_FRONT, V_SYNC, V_BACK));

   logic [HW-1:0]   hcnt;
   logic [VW-1:0]   vcnt;
   logic            frame_end, pix_vld;
   state_e          state_q, state_d;
   pattern_e        pat_q, pat_d;
   logic [7:0]      frame_cnt_q, frame_cnt_d;
   logic [BITS-1:0] data_q, data_d;
   logic            frame_done_q, frame_done_d;
   logic            busy_q, busy_d;
   logic [2:0]      bar;
   logic [BITS-1:0] px;

   vip_dvp_timing #(
      .H_DISP (H_DISP),
      .H_FRONT(H_FRONT),
      .H_SYNC (H_SYNC),
      .H_BACK (H_BACK),
      .V_DISP (V_DISP),
      .V_FRONT(V_FRONT),
      .V_SYNC (V_SYNC),
      .V_BACK (V_BACK)
   ) u_timing (
      .clk      (pclk),
      .rst_n    (rst_n),
      .run      (state_q == ST_RUN),
      .hcnt     (hcnt),
      .vcnt     (vcnt),
      .frame_end(frame_end),
      .pix_vld  (pix_vld),
      .href     (out_href),
      .hsync    (out_hsync),
      .vsync    (out_vsync)
   );

   always_comb begin
      state_d     = state_q;
      pat_d       = pat_q;
      frame_cnt_d = frame_cnt_q;
      case (state_q)
         ST_IDLE: if (enable) begin
            state_d = ST_RUN;
            pat_d   = pattern_e'(pattern);
         end
         ST_RUN: if (frame_end) begin
            if (enable) pat_d = pattern_e'(pattern);
            else        state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // Counted at the frame-end edge so the next frame's first pixel sees the new count.
      if (frame_end) frame_cnt_d = frame_cnt_q + 8'd1;
      frame_done_d = frame_end;
      busy_d       = (state_d == ST_RUN) || frame_end;

      bar = '0;
      for (int unsigned k = 1; k < 8; k++) begin
         if (32'(hcnt) >= bar_edge(k, H_DISP)) bar = 3'(k);
      end

      case (pat_q)
         PAT_HRAMP: px = BITS'(hcnt);
         PAT_VRAMP: px = BITS'(vcnt);
         PAT_BARS:  px = BITS'(bar) << (BITS - 3);
         PAT_CHECK: px = (BITS'(hcnt) ^ BITS'(vcnt)) + BITS'(frame_cnt_q);
         default:   px = '0;
      endcase
      data_d = pix_vld ? px : '0;
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         pat_q        <= PAT_HRAMP;
         frame_cnt_q  <= '0;
         data_q       <= '0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         pat_q        <= pat_d;
         frame_cnt_q  <= frame_cnt_d;
         data_q       <= data_d;
         frame_done_q <= frame_done_d;
         busy_q       <= busy_d;
      end
   end

   assign out_data   = data_q;
   assign frame_done = frame_done_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_vip_dvp_gen.sv
// Directed bench for vip_dvp_gen: expected output slots are queued when the
// stimulus is applied and compared one per pclk cycle.
module tb_vip_dvp_gen;

   localparam int unsigned BITS    = 8;
   localparam int unsigned H_DISP  = 8;
   localparam int unsigned H_FRONT = 2;
   localparam int unsigned H_SYNC  = 2;
   localparam int unsigned H_BACK  = 2;
   localparam int unsigned V_DISP  = 4;
   localparam int unsigned V_FRONT = 1;
   localparam int unsigned V_SYNC  = 1;
   localparam int unsigned V_BACK  = 1;
   localparam int unsigned HT = 14;
   localparam int unsigned VT = 7;

   logic            pclk = 1'b0;
   logic            rst_n;
   logic            enable;
   logic [1:0]      pattern;
   logic            out_href, out_hsync, out_vsync, frame_done, busy;
   logic [BITS-1:0] out_data;

   int total = 0;
   int bad = 0;
   int slot_no = 0;
   logic [12:0] sb[$];

   vip_dvp_gen #(
      .BITS   (BITS),
      .H_DISP (H_DISP),
      .H_FRONT(H_FRONT),
      .H_SYNC (H_SYNC),
      .H_BACK (H_BACK),
      .V_DISP (V_DISP),
      .V_FRONT(V_FRONT),
      .V_SYNC (V_SYNC),
      .V_BACK (V_BACK)
   ) dut (
      .pclk      (pclk),
      .rst_n     (rst_n),
      .enable    (enable),
      .pattern   (pattern),
      .out_href  (out_href),
      .out_hsync (out_hsync),
      .out_vsync (out_vsync),
      .out_data  (out_data),
      .frame_done(frame_done),
      .busy      (busy)
   );

   always #5 pclk = ~pclk;

   // Slot layout: {busy, frame_done, href, hsync, vsync, data[7:0]}
   function automatic logic [12:0] obs();
      return {busy, frame_done, out_href, out_hsync, out_vsync, out_data};
   endfunction

   task automatic check(input string tag, input logic [12:0] o, input logic [12:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s slot=%0d observed=%h expected=%h", tag, slot_no, o, e);
      end
   endtask

   task automatic push_const(input int n, input logic [12:0] v);
      for (int i = 0; i < n; i++) sb.push_back(v);
   endtask

   task automatic push_frame(input int pat, input int fcnt);
      for (int v = 0; v < int'(VT); v++) begin
         for (int h = 0; h < int'(HT); h++) begin
            logic hr, hs, vs, fd;
            logic [7:0] d;
            hr = (h < 8) && (v < 4);
            hs = (h >= 10) && (h < 12);
            vs = (v == 5);
            fd = (h == 13) && (v == 6);
            d  = 8'h00;
            if (hr) begin
               case (pat)
                  0:       d = 8'(h);
                  1:       d = 8'(v);
                  2:       d = 8'(((h * 8) / 8) * 32);
                  default: d = 8'((h ^ v) + fcnt);
               endcase
            end
            sb.push_back({1'b1, fd, hr, hs, vs, d});
         end
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge pclk);
         if (sb.size() > 0) begin
            check("slot", obs(), sb.pop_front());
            slot_no++;
         end
      end
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (sb.size() > 0 && guard < 2000) begin
         tick(1);
         guard++;
      end
      if (sb.size() > 0) check("drain_timeout", 13'd1, 13'd0);
   endtask

   initial begin
      rst_n   = 1'b0;
      enable  = 1'b0;
      pattern = 2'd0;
      repeat (2) @(negedge pclk);
      check("reset_state", obs(), 13'h0);
      rst_n = 1'b1;
      push_const(3, 13'h0);
      tick(3);

      // Frame 1 horizontal ramp, frame 2 bars, stop requested mid frame 2
      enable  = 1'b1;
      pattern = 2'd0;
      push_const(2, 13'h1000);
      push_frame(0, 0);
      tick(50);
      pattern = 2'd2;
      push_frame(2, 1);
      tick(80);
      enable = 1'b0;
      push_const(4, 13'h0);
      drain();

      // Frame 3 checker with pattern changed mid-frame, frame 4 ramp, frame 5 vramp
      pattern = 2'd3;
      enable  = 1'b1;
      push_const(2, 13'h1000);
      push_frame(3, 2);
      tick(40);
      pattern = 2'd0;
      push_frame(0, 3);
      tick(60);
      pattern = 2'd1;
      push_frame(1, 4);
      tick(98);
      tick(18);

      check("href_before_reset", {12'h0, out_href}, 13'h1);
      #1 rst_n = 1'b0;
      #1 check("async_reset", obs(), 13'h0);
      sb.delete();
      @(negedge pclk);
      check("held_in_reset", obs(), 13'h0);

      pattern = 2'd0;
      rst_n   = 1'b1;
      push_const(2, 13'h1000);
      push_frame(0, 0);
      tick(50);
      enable = 1'b0;
      push_const(3, 13'h0);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
